// File: rtl/rst_clear_sched.sv
// Clear scheduler for the register status table: turns multi-hot clear requests into one
// round-robin clear per cycle, and runs a full-table flush walk on branch-mispredict recovery.
module rst_clear_sched #(
    parameter int NUM_ENT   = 32,
    parameter int ADDR_W    = 5,
    parameter int IDLE_ADDR = 31
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_ENT-1:0] req_vec,
    input  logic               flush,
    input  logic               stall,
    output logic [ADDR_W-1:0]  clr_addr,
    output logic               clr_en,
    output logic [NUM_ENT-1:0] pending,
    output logic               busy,
    output logic               flush_done
);

    localparam logic [ADDR_W-1:0]  IDLE_A   = ADDR_W'(IDLE_ADDR);
    localparam logic [ADDR_W-1:0]  LAST_A   = ADDR_W'(NUM_ENT - 1);
    localparam logic [ADDR_W-1:0]  ZERO_A   = {ADDR_W{1'b0}};
    localparam logic [NUM_ENT-1:0] ZERO_V   = {NUM_ENT{1'b0}};
    localparam logic [NUM_ENT-1:0] ONE_V    = NUM_ENT'(1);

    typedef enum logic [0:0] {
        ST_SERVE = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [NUM_ENT-1:0]  pending_q, pending_d;
    logic [ADDR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ADDR_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
    logic                clr_en_q, clr_en_d;
    logic                flush_done_q, flush_done_d;

    logic [NUM_ENT-1:0]  cand_s;
    logic [NUM_ENT-1:0]  below_s;
    logic [ADDR_W:0]     pick_s;
    logic                gnt_found_s;
    logic [ADDR_W-1:0]   gnt_idx_s;

    // Scanning offsets from high to low lets the closest set bit at or above ptr win.
    function automatic logic [ADDR_W:0] rr_pick(input logic [NUM_ENT-1:0] vec,
                                                 input logic [ADDR_W-1:0]  ptr);
        logic [ADDR_W-1:0] idx;
        logic [ADDR_W:0]   res;
        res = {1'b0, ZERO_A};
        for (int k = NUM_ENT - 1; k >= 0; k--) begin
            idx = ptr + ADDR_W'(k);
            if (vec[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    assign cand_s      = pending_q | req_vec;
    assign below_s     = (ONE_V << flush_cnt_q) - ONE_V;
    assign pick_s      = rr_pick(cand_s, rr_ptr_q);
    assign gnt_found_s = pick_s[ADDR_W];
    assign gnt_idx_s   = pick_s[ADDR_W-1:0];

    // Next-state logic for arbitration and the flush walk.
    always_comb begin
        state_d      = state_q;
        pending_d    = pending_q;
        rr_ptr_d     = rr_ptr_q;
        flush_cnt_d  = flush_cnt_q;
        clr_en_d     = 1'b0;
        clr_addr_d   = IDLE_A;
        flush_done_d = 1'b0;
        case (state_q)
            ST_SERVE: begin
                if (flush) begin
                    state_d     = ST_FLUSH;
                    flush_cnt_d = ZERO_A;
                    pending_d   = ZERO_V;
                end else if (!stall && gnt_found_s) begin
                    clr_en_d   = 1'b1;
                    clr_addr_d = gnt_idx_s;
                    rr_ptr_d   = gnt_idx_s + ADDR_W'(1);
                    pending_d  = cand_s & ~(ONE_V << gnt_idx_s);
                end else begin
                    pending_d = cand_s;
                end
            end
            ST_FLUSH: begin
                // Entries at or above the walk position will still be cleared by the walk.
                pending_d = pending_q | (req_vec & below_s);
                if (!stall) begin
                    clr_en_d    = 1'b1;
                    clr_addr_d  = flush_cnt_q;
                    flush_cnt_d = flush_cnt_q + ADDR_W'(1);
                    if (flush_cnt_q == LAST_A) begin
                        flush_done_d = 1'b1;
                        state_d      = ST_SERVE;
                        rr_ptr_d     = ZERO_A;
                    end else begin
                        state_d = ST_FLUSH;
                    end
                end else begin
                    flush_cnt_d = flush_cnt_q;
                end
            end
            default: begin
                state_d     = ST_SERVE;
                pending_d   = ZERO_V;
                rr_ptr_d    = ZERO_A;
                flush_cnt_d = ZERO_A;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_SERVE;
            pending_q    <= ZERO_V;
            rr_ptr_q     <= ZERO_A;
            flush_cnt_q  <= ZERO_A;
            clr_en_q     <= 1'b0;
            clr_addr_q   <= IDLE_A;
            flush_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            rr_ptr_q     <= rr_ptr_d;
            flush_cnt_q  <= flush_cnt_d;
            clr_en_q     <= clr_en_d;
            clr_addr_q   <= clr_addr_d;
            flush_done_q <= flush_done_d;
        end
    end

    assign clr_addr   = clr_addr_q;
    assign clr_en     = clr_en_q;
    assign pending    = pending_q;
    assign flush_done = flush_done_q;
    assign busy       = (pending_q != ZERO_V) || (state_q == ST_FLUSH);

endmodule

// File: tb/tb_rst_clear_sched.sv
// Testbench for rst_clear_sched: directed plan steps plus randomized traffic, checked against
// an integer-level reference model of the scheduling rules.
module tb_rst_clear_sched;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] req_vec = 32'h0;
    logic        flush = 1'b0;
    logic        stall = 1'b0;
    logic [4:0]  clr_addr;
    logic        clr_en;
    logic [31:0] pending;
    logic        busy;
    logic        flush_done;

    int tests = 0;
    int fails = 0;

    // Reference model state.
    bit [31:0] m_pend;
    int        m_rr;
    int        m_fcnt;
    bit        m_in_flush;
    bit        m_en;
    int        m_addr;
    bit        m_done;

    rst_clear_sched #(.NUM_ENT(32), .ADDR_W(5), .IDLE_ADDR(31)) dut (
        .clk(clk), .reset(reset), .req_vec(req_vec), .flush(flush), .stall(stall),
        .clr_addr(clr_addr), .clr_en(clr_en), .pending(pending), .busy(busy),
        .flush_done(flush_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 32'h0; m_rr = 0; m_fcnt = 0; m_in_flush = 1'b0;
        m_en = 1'b0; m_addr = 31; m_done = 1'b0;
    endtask

    task automatic model_step(input bit [31:0] r, input bit f, input bit s);
        bit [31:0] cand;
        int g;
        m_done = 1'b0;
        if (!m_in_flush) begin
            cand = m_pend | r;
            if (f) begin
                m_in_flush = 1'b1; m_fcnt = 0; m_pend = 32'h0; m_en = 1'b0; m_addr = 31;
            end else if (!s && cand != 32'h0) begin
                g = -1;
                for (int k = 0; k < 32; k++)
                    if (g < 0 && cand[(m_rr + k) % 32]) g = (m_rr + k) % 32;
                m_en = 1'b1; m_addr = g; m_rr = (g + 1) % 32;
                m_pend = cand; m_pend[g] = 1'b0;
            end else begin
                m_en = 1'b0; m_addr = 31; m_pend = cand;
            end
        end else begin
            for (int i = 0; i < m_fcnt; i++)
                if (r[i]) m_pend[i] = 1'b1;
            if (!s) begin
                m_en = 1'b1; m_addr = m_fcnt;
                if (m_fcnt == 31) begin
                    m_done = 1'b1; m_in_flush = 1'b0; m_rr = 0; m_fcnt = 0;
                end else begin
                    m_fcnt++;
                end
            end else begin
                m_en = 1'b0; m_addr = 31;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_en"}, 32'(clr_en), 32'(m_en));
        if (m_en) check({tag, "_addr"}, 32'(clr_addr), 32'(m_addr));
        else      check({tag, "_idle_addr"}, 32'(clr_addr), 32'd31);
        check({tag, "_pend"}, pending, m_pend);
        check({tag, "_done"}, 32'(flush_done), 32'(m_done));
        check({tag, "_busy"}, 32'(busy), 32'((m_pend != 32'h0) || m_in_flush));
    endtask

    // Drive one cycle of inputs, advance the model, and compare after the edge.
    task automatic step(input string tag, input logic [31:0] r, input logic f, input logic s);
        req_vec = r; flush = f; stall = s;
        model_step(r, f, s);
        @(posedge clk);
        #1;
        compare_all(tag);
        req_vec = 32'h0; flush = 1'b0; stall = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        compare_all("reset");
        check("reset_en", 32'(clr_en), 32'd0);
        check("reset_addr", 32'(clr_addr), 32'd31);
    endtask

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Single request
        step("t1a", 32'h00000010, 1'b0, 1'b0);
        check("t1_addr", 32'(clr_addr), 32'd4);
        step("t1b", 32'h0, 1'b0, 1'b0);
        check("t1_busy", 32'(busy), 32'd0);

        // Multi-hot round-robin from rr_ptr 0
        do_reset();
        step("t2a", 32'h80000005, 1'b0, 1'b0);
        check("t2_g0", 32'(clr_addr), 32'd0);
        step("t2b", 32'h0, 1'b0, 1'b0);
        check("t2_g2", 32'(clr_addr), 32'd2);
        step("t2c", 32'h0, 1'b0, 1'b0);
        check("t2_g31", 32'(clr_addr), 32'd31);
        step("t2d", 32'h00000003, 1'b0, 1'b0);
        check("t2_wrap0", 32'(clr_addr), 32'd0);
        step("t2e", 32'h0, 1'b0, 1'b0);
        check("t2_g1", 32'(clr_addr), 32'd1);

        // Stall holds requests
        for (int i = 0; i < 3; i++) begin
            step("t3s", (i == 0) ? 32'h00000300 : 32'h0, 1'b0, 1'b1);
            check("t3_pend", pending, 32'h00000300);
        end
        step("t3a", 32'h0, 1'b0, 1'b0);
        check("t3_g8", 32'(clr_addr), 32'd8);
        step("t3b", 32'h0, 1'b0, 1'b0);
        check("t3_g9", 32'(clr_addr), 32'd9);

        // Merge and same-cycle re-request of the granted entry
        step("t4a", 32'h00000006, 1'b0, 1'b1);
        step("t4b", 32'h00000002, 1'b0, 1'b0);
        check("t4_g1", 32'(clr_addr), 32'd1);
        step("t4c", 32'h0, 1'b0, 1'b0);
        check("t4_g2", 32'(clr_addr), 32'd2);
        check("t4_pend0", pending, 32'h0);

        // Flush walk with late requests
        step("t5p", 32'hFFFF0000, 1'b0, 1'b1);
        step("t5f", 32'h0, 1'b1, 1'b0);
        check("t5_flush_pend", pending, 32'h0);
        for (int i = 0; i < 32; i++) begin
            step("t5w", (i == 10) ? 32'h00100008 : 32'h0, (i == 5) ? 1'b1 : 1'b0, 1'b0);
            check("t5_walk_addr", 32'(clr_addr), 32'(i));
            check("t5_walk_done", 32'(flush_done), (i == 31) ? 32'd1 : 32'd0);
        end
        check("t5_kept3", pending, 32'h00000008);
        step("t5g", 32'h0, 1'b0, 1'b0);
        check("t5_g3", 32'(clr_addr), 32'd3);

        // Asynchronous reset mid-flush
        step("t6f", 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) step("t6w", 32'h0, 1'b0, 1'b0);
        step("t6q", 32'h00000040, 1'b0, 1'b1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("t6_async_en", 32'(clr_en), 32'd0);
        check("t6_async_addr", 32'(clr_addr), 32'd31);
        check("t6_async_pend", pending, 32'h0);
        check("t6_async_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        step("t6r", 32'h00000800, 1'b0, 1'b0);
        check("t6_resume", 32'(clr_addr), 32'd11);
        for (int i = 0; i < 20; i++) step("t6n", 32'h0, 1'b0, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic [31:0] r;
            r = $urandom & $urandom & $urandom;
            if ($urandom_range(0, 3) == 0) r = 32'h0;
            step("rnd", r, ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
